instr_fetch_unit: RTL and testbench

- Produces the instruction stream that the single-cycle core consumes on its `instr` input.
- Owns the PC and issues in-order read requests to instruction memory over a valid/ready request channel.
- Buffers returned words in a prefetch FIFO and hands them to the core with a valid/ready handshake.
- Flushes and redirects on taken branches.

---
 rtl/instr_fetch_unit_if.sv | 27 ++
 rtl/instr_fetch_unit.sv | 187 ++++++++++++++++++
 tb/tb_instr_fetch_unit.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_unit_if.sv
// Port bundle for instr_fetch_unit: instruction-memory request/response channel,
// core-side instruction handshake and the branch redirect.
interface instr_fetch_unit_if;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_resp_valid;
   logic [31:0] imem_resp_data;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        instr_valid;
   logic        instr_ready;
   logic        redirect;
   logic [31:0] redirect_pc;

   modport master (
      output imem_req_valid, imem_req_addr, instr, instr_pc, instr_valid,
      input  imem_req_ready, imem_resp_valid, imem_resp_data, instr_ready,
      input  redirect, redirect_pc
   );

   modport slave (
      input  imem_req_valid, imem_req_addr, instr, instr_pc, instr_valid,
      output imem_req_ready, imem_resp_valid, imem_resp_data, instr_ready,
      output redirect, redirect_pc
   );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, keeps in-order reads in flight and buffers words in a
// prefetch FIFO for the core. Defining IFU_PERF_EN adds fetched/stall/flush counters.
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   instr_fetch_unit_if.master bus
`ifdef IFU_PERF_EN
   ,
   output logic [31:0]        perf_fetched,
   output logic [31:0]        perf_stall,
   output logic [15:0]        perf_flush
`endif
);

   localparam int unsigned   AW      = $clog2(FIFO_DEPTH);
   localparam int unsigned   CW      = AW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
   localparam logic [31:0]   NOP     = 32'h0000_0013;

   logic [31:0]   pc_q, pc_d;
   logic [31:0]   rspPc_q, rspPc_d;
   logic [CW-1:0] outst_q, outst_d;
   logic [CW-1:0] drop_q, drop_d;
   logic [CW-1:0] count_q, count_d;
   logic [AW-1:0] rdPtr_q, rdPtr_d;
   logic [AW-1:0] wrPtr_q, wrPtr_d;
   logic [31:0]   memData_q [FIFO_DEPTH];
   logic [31:0]   memPc_q   [FIFO_DEPTH];
   logic [31:0]   instr_q, instr_d;
   logic [31:0]   instrPc_q, instrPc_d;
   logic          instrValid_q, instrValid_d;

   logic [CW:0]   credit;
   logic          reqValid;
   logic          reqFire;
   logic          respDec;
   logic          pushEn;
   logic          popEn;

   // Entries buffered plus requests in flight never exceed the FIFO depth, so every
   // response is guaranteed a free slot.
   assign credit   = {1'b0, count_q} + {1'b0, outst_q};
   assign reqValid = rst_n && !bus.redirect && (credit < {1'b0, DEPTH_C});
   assign reqFire  = reqValid && bus.imem_req_ready;
   assign respDec  = bus.imem_resp_valid && (outst_q != '0);
   assign pushEn   = respDec && !bus.redirect && (drop_q == '0);
   assign popEn    = instrValid_q && bus.instr_ready;

   assign bus.imem_req_valid = reqValid;
   assign bus.imem_req_addr  = pc_q;
   assign bus.instr          = instr_q;
   assign bus.instr_pc       = instrPc_q;
   assign bus.instr_valid    = instrValid_q;

   always_comb begin
      pc_d    = pc_q;
      rspPc_d = rspPc_q;
      drop_d  = drop_q;
      count_d = count_q;
      rdPtr_d = rdPtr_q;
      wrPtr_d = wrPtr_q;
      outst_d = outst_q;
      if (reqFire && !respDec) begin
         outst_d = outst_q + CW'(1);
      end else if (!reqFire && respDec) begin
         outst_d = outst_q - CW'(1);
      end
      if (bus.redirect) begin
         pc_d    = {bus.redirect_pc[31:2], 2'b00};
         rspPc_d = {bus.redirect_pc[31:2], 2'b00};
         count_d = '0;
         rdPtr_d = '0;
         wrPtr_d = '0;
         // Everything still in flight belongs to the old stream and must be discarded.
         drop_d  = outst_d;
      end else begin
         if (reqFire) begin
            pc_d = pc_q + 32'd4;
         end
         if (respDec && (drop_q != '0)) begin
            drop_d = drop_q - CW'(1);
         end
         if (pushEn) begin
            wrPtr_d = wrPtr_q + AW'(1);
            rspPc_d = rspPc_q + 32'd4;
         end
         if (popEn) begin
            rdPtr_d = rdPtr_q + AW'(1);
         end
         if (pushEn && !popEn) begin
            count_d = count_q + CW'(1);
         end else if (!pushEn && popEn) begin
            count_d = count_q - CW'(1);
         end
      end
   end

   // Next head of the FIFO, bypassing the incoming word when it lands in an empty FIFO.
   always_comb begin
      instrValid_d = (count_d != '0);
      instr_d      = NOP;
      instrPc_d    = '0;
      if (instrValid_d) begin
         if (pushEn && (wrPtr_q == rdPtr_d)) begin
            instr_d   = bus.imem_resp_data;
            instrPc_d = rspPc_q;
         end else begin
            instr_d   = memData_q[rdPtr_d];
            instrPc_d = memPc_q[rdPtr_d];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q         <= RESET_PC;
         rspPc_q      <= RESET_PC;
         outst_q      <= '0;
         drop_q       <= '0;
         count_q      <= '0;
         rdPtr_q      <= '0;
         wrPtr_q      <= '0;
         instr_q      <= NOP;
         instrPc_q    <= '0;
         instrValid_q <= 1'b0;
      end else begin
         pc_q         <= pc_d;
         rspPc_q      <= rspPc_d;
         outst_q      <= outst_d;
         drop_q       <= drop_d;
         count_q      <= count_d;
         rdPtr_q      <= rdPtr_d;
         wrPtr_q      <= wrPtr_d;
         instr_q      <= instr_d;
         instrPc_q    <= instrPc_d;
         instrValid_q <= instrValid_d;
      end
   end

   always_ff @(posedge clk) begin
      if (pushEn) begin
         memData_q[wrPtr_q] <= bus.imem_resp_data;
         memPc_q[wrPtr_q]   <= rspPc_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst_n) begin
         if (pushEn) begin
            assert (count_q < DEPTH_C);
         end
         assert (drop_q <= outst_q);
      end
   end

`ifdef IFU_PERF_EN
   logic [31:0] fetched_q;
   logic [31:0] stall_q;
   logic [15:0] flush_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetched_q <= '0;
         stall_q   <= '0;
         flush_q   <= '0;
      end else begin
         if (popEn) begin
            fetched_q <= fetched_q + 32'd1;
         end
         if (bus.instr_ready && !instrValid_q) begin
            stall_q <= stall_q + 32'd1;
         end
         if (bus.redirect) begin
            flush_q <= flush_q + 16'd1;
         end
      end
   end

   assign perf_fetched = fetched_q;
   assign perf_stall   = stall_q;
   assign perf_flush   = flush_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios plus randomized latency,
// back-pressure and redirects, checked against a queue model of the instruction stream.
module tb_instr_fetch_unit;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam int          DEPTH    = 4;
   localparam logic [31:0] NOP      = 32'h0000_0013;

   typedef struct {
      logic [31:0] addr;
      bit          stale;
      int          due;
   } req_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;

   instr_fetch_unit_if bus ();

`ifdef IFU_PERF_EN
   logic [31:0] perfFetched;
   logic [31:0] perfStall;
   logic [15:0] perfFlush;
`endif

   instr_fetch_unit #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
`ifdef IFU_PERF_EN
      ,
      .perf_fetched (perfFetched),
      .perf_stall   (perfStall),
      .perf_flush   (perfFlush)
`endif
   );

   always #5 clk = ~clk;

   req_t        inflight[$];
   logic [31:0] fifoPc[$];
   logic [31:0] mPc;
   logic [31:0] dutReqs[$];
   logic [31:0] dutPops[$];
   logic [31:0] dutPopData[$];
   int          cycleNo, checksPassed, checksTotal;
   int          firstAccept, firstValid;
   int          flushCount, popCount, stallCount;
   int          latMin, latMax;
   bit          drvReady, drvInstrReady, drvRedirect, randomMode;
   logic [31:0] drvRedirectPc;
   bit          pinArmed;
   logic [31:0] pinAddr;

   // Memory contents are a fixed function of the address.
   function automatic logic [31:0] memData(input logic [31:0] addr);
      return {addr[15:0], ~addr[15:0]} ^ 32'h5A5A_0000;
   endfunction

   function automatic void cmp32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checksTotal++;
      if (act === exp) checksPassed++;
      else $display("[TB] FAIL %s: actual=%08h required=%08h (cycle %0d)", name, act, exp, cycleNo);
   endfunction

   function automatic void cmpBit(input string name, input logic act, input logic exp);
      checksTotal++;
      if (act === exp) checksPassed++;
      else $display("[TB] FAIL %s: actual=%b required=%b (cycle %0d)", name, act, exp, cycleNo);
   endfunction

   function automatic void cmpInt(input string name, input int act, input int exp);
      checksTotal++;
      if (act == exp) checksPassed++;
      else $display("[TB] FAIL %s: actual=%0d required=%0d", name, act, exp);
   endfunction

   function automatic logic [31:0] firstOf(input logic [31:0] q[$]);
      return (q.size() != 0) ? q[0] : 32'hDEAD_BEEF;
   endfunction

   task automatic driveIdle();
      bus.imem_req_ready  = 1'b0;
      bus.imem_resp_valid = 1'b0;
      bus.imem_resp_data  = '0;
      bus.instr_ready     = 1'b0;
      bus.redirect        = 1'b0;
      bus.redirect_pc     = '0;
   endtask

   task automatic clearModel();
      inflight.delete();
      fifoPc.delete();
      dutReqs.delete();
      dutPops.delete();
      dutPopData.delete();
      mPc         = RESET_PC;
      cycleNo     = 0;
      firstAccept = -1;
      firstValid  = -1;
      flushCount  = 0;
      popCount    = 0;
      stallCount  = 0;
      drvRedirect = 1'b0;
      pinArmed    = 1'b0;
   endtask

   task automatic resetDut();
      rst_n = 1'b0;
      driveIdle();
      clearModel();
      @(negedge clk);
      cmpBit("reset instr_valid", bus.instr_valid, 1'b0);
      cmp32("reset instr", bus.instr, NOP);
      cmp32("reset instr_pc", bus.instr_pc, 32'h0);
      cmpBit("reset req_valid", bus.imem_req_valid, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic applyStimulus();
      if (randomMode) begin
         drvReady      = ($urandom_range(0, 3) != 0);
         drvInstrReady = ($urandom_range(0, 3) != 0);
         drvRedirect   = ($urandom_range(0, 15) == 0);
         drvRedirectPc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFE0 | 32'($urandom_range(0, 31)))
                                                     : $urandom;
      end
      bus.imem_req_ready = drvReady;
      bus.instr_ready    = drvInstrReady;
      bus.redirect       = drvRedirect;
      bus.redirect_pc    = drvRedirectPc;
      if (inflight.size() != 0 && inflight[0].due <= cycleNo) begin
         bus.imem_resp_valid = 1'b1;
         bus.imem_resp_data  = memData(inflight[0].addr);
      end else begin
         bus.imem_resp_valid = 1'b0;
         bus.imem_resp_data  = $urandom;
      end
   endtask

   task automatic checkOutput();
      bit          expValid;
      bit          hasHead;
      expValid = !drvRedirect && (fifoPc.size() + inflight.size() < DEPTH);
      hasHead  = (fifoPc.size() != 0);
      cmpBit("instr_valid", bus.instr_valid, hasHead);
      cmp32("instr", bus.instr, hasHead ? memData(fifoPc[0]) : NOP);
      cmp32("instr_pc", bus.instr_pc, hasHead ? fifoPc[0] : 32'h0);
      cmpBit("req_valid", bus.imem_req_valid, expValid);
      if (expValid) cmp32("req_addr", bus.imem_req_addr, mPc);
      if (pinArmed) begin
         cmpBit("pinned req_valid", bus.imem_req_valid, 1'b1);
         cmp32("pinned req_addr", bus.imem_req_addr, pinAddr);
         pinArmed = 1'b0;
      end
      if (bus.imem_req_valid && drvReady) begin
         dutReqs.push_back(bus.imem_req_addr);
         if (firstAccept < 0) firstAccept = cycleNo;
      end
      if (bus.instr_valid && firstValid < 0) firstValid = cycleNo;
      if (bus.instr_valid && drvInstrReady && !drvRedirect) begin
         dutPops.push_back(bus.instr_pc);
         dutPopData.push_back(bus.instr);
      end
   endtask

   // Advance the model across one rising edge using this cycle's inputs.
   task automatic modelEdge();
      bit   respNow, popNow, reqFire;
      req_t r;
      respNow = bus.imem_resp_valid;
      popNow  = (fifoPc.size() != 0) && drvInstrReady;
      reqFire = !drvRedirect && (fifoPc.size() + inflight.size() < DEPTH) && drvReady;
      if (popNow) popCount++;
      if (drvInstrReady && fifoPc.size() == 0) stallCount++;
      r = '{addr: 32'h0, stale: 1'b1, due: 0};
      if (respNow) r = inflight.pop_front();
      if (drvRedirect) begin
         flushCount++;
         fifoPc.delete();
         foreach (inflight[i]) inflight[i].stale = 1'b1;
         mPc = {drvRedirectPc[31:2], 2'b00};
      end else begin
         if (popNow) void'(fifoPc.pop_front());
         if (respNow && !r.stale) fifoPc.push_back(r.addr);
         if (reqFire) begin
            inflight.push_back('{addr: mPc, stale: 1'b0,
                                 due: cycleNo + int'($urandom_range(latMin, latMax))});
            mPc = mPc + 32'd4;
         end
      end
   endtask

   task automatic stepCycle();
      applyStimulus();
      #1;
      checkOutput();
      modelEdge();
      @(posedge clk);
      @(negedge clk);
      cycleNo++;
   endtask

   task automatic redirectStep(input logic [31:0] target);
      drvRedirect   = 1'b1;
      drvRedirectPc = target;
      stepCycle();
      drvRedirect   = 1'b0;
   endtask

   initial begin
      checksPassed = 0;
      checksTotal  = 0;
      randomMode   = 1'b0;
      drvRedirectPc = '0;
      driveIdle();
      #1;

      // Streaming with single-cycle memory.
      resetDut();
      latMin = 1; latMax = 1; drvReady = 1'b1; drvInstrReady = 1'b1;
      repeat (10) stepCycle();
      for (int i = 0; i < 4; i++)
         cmp32("stream req addr", (dutReqs.size() > i) ? dutReqs[i] : 32'hDEAD_BEEF, 32'(i * 4));
      cmpInt("accept to valid latency", firstValid - firstAccept, 2);
      cmpInt("stream pop count", dutPops.size(), 8);
      for (int i = 0; i < 8; i++)
         cmp32("stream pop pc", (dutPops.size() > i) ? dutPops[i] : 32'hDEAD_BEEF, 32'(i * 4));

      // Core stalled: credits allow exactly DEPTH requests.
      resetDut();
      drvInstrReady = 1'b0;
      repeat (10) stepCycle();
      cmpInt("stalled accepts", dutReqs.size(), 4);
      cmpBit("stalled req_valid", bus.imem_req_valid, 1'b0);
      cmpBit("stalled instr_valid", bus.instr_valid, 1'b1);
      cmp32("stalled instr_pc", bus.instr_pc, 32'h0);
      drvInstrReady = 1'b1;
      repeat (6) stepCycle();
      cmpBit("resume fetch", dutReqs.size() > 4, 1'b1);

      // Redirect with two requests outstanding on a 3-cycle memory.
      resetDut();
      latMin = 3; latMax = 3;
      repeat (2) stepCycle();
      drvReady = 1'b0;
      cmpInt("outstanding before redirect", inflight.size(), 2);
      redirectStep(32'h0000_0100);
      drvReady = 1'b1;
      dutPops.delete();
      dutPopData.delete();
      repeat (12) stepCycle();
      cmp32("redirect first pc", firstOf(dutPops), 32'h0000_0100);
      cmp32("redirect first data", firstOf(dutPopData), 32'h5B5A_FEFF);

      // Redirect coinciding with a response and a pop.
      resetDut();
      latMin = 1; latMax = 1;
      repeat (5) stepCycle();
      cmpBit("coincide head valid", bus.instr_valid, 1'b1);
      redirectStep(32'h0000_0400);
      cmpBit("flushed instr_valid", bus.instr_valid, 1'b0);
      pinArmed = 1'b1; pinAddr = 32'h0000_0400;
      dutPops.delete();
      repeat (6) stepCycle();
      cmp32("post-flush first pc", firstOf(dutPops), 32'h0000_0400);

      // Unaligned redirect target.
      latMin = 2; latMax = 2;
      redirectStep(32'h0000_0203);
      pinArmed = 1'b1; pinAddr = 32'h0000_0200;
      dutPops.delete();
      repeat (8) stepCycle();
      cmp32("aligned first pc", firstOf(dutPops), 32'h0000_0200);

      // Asynchronous reset while the FIFO holds two entries.
      resetDut();
      latMin = 1; latMax = 1; drvInstrReady = 1'b0;
      repeat (3) stepCycle();
      cmpInt("fifo half full", fifoPc.size(), 2);
      #2 rst_n = 1'b0;
      #1;
      cmpBit("async reset instr_valid", bus.instr_valid, 1'b0);
      cmp32("async reset instr", bus.instr, NOP);
      cmp32("async reset instr_pc", bus.instr_pc, 32'h0);
      cmpBit("async reset req_valid", bus.imem_req_valid, 1'b0);
      driveIdle();
      clearModel();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      drvInstrReady = 1'b1;
      pinArmed = 1'b1; pinAddr = RESET_PC;
      repeat (6) stepCycle();

      // Randomized traffic.
      latMin = 1; latMax = 4; randomMode = 1'b1;
      repeat (1500) stepCycle();
      randomMode = 1'b0;
      drvRedirect = 1'b0;

`ifdef IFU_PERF_EN
      cmp32("perf_fetched", perfFetched, 32'(popCount));
      cmp32("perf_stall", perfStall, 32'(stallCount));
      cmp32("perf_flush", {16'h0, perfFlush}, {16'h0, flushCount[15:0]});
`endif

      $display("%0d/%0d checks passed", checksPassed, checksTotal);
      $finish;
   end

endmodule
